// File: rtl/and_stim_checker.sv
// Stimulus generator and response checker for a clocked two-input AND cell.
// Drives all four {a,b} combinations, compares the returned y after LATENCY cycles.
module and_stim_checker #(
    parameter int HOLD_CYCLES = 1,
    parameter int LATENCY     = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             fail_flag,
    output logic [1:0]       err_vec
);

    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DRAIN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_ZERO  = HOLD_W'(0);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((LATENCY > 0) ? (LATENCY - 1) : 0);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_ZERO = DRAIN_W'(0);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [1:0]         vec_idx_r;
    logic [1:0]         vec_idx_nxt_s;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic [HOLD_W-1:0]  hold_cnt_nxt_s;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic [DRAIN_W-1:0] drain_cnt_nxt_s;

    logic               a_r;
    logic               b_r;
    logic               busy_r;
    logic               done_r;
    logic               drive_nxt_s;
    logic [CNT_W-1:0]   pass_cnt_r;
    logic [CNT_W-1:0]   fail_cnt_r;
    logic               fail_flag_r;
    logic [1:0]         err_vec_r;

    logic               accept_s;
    logic [3:0]         cur_s;
    logic [3:0]         chk_s;
    logic               chk_valid_s;
    logic               chk_exp_s;
    logic [1:0]         chk_ab_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : (v + {{(CNT_W-1){1'b0}}, 1'b1});
    endfunction

    assign accept_s = (state_r == ST_IDLE) && start;

    // FSM state and sequencing counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            vec_idx_r   <= 2'd0;
            hold_cnt_r  <= HOLD_ZERO;
            drain_cnt_r <= DRAIN_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            vec_idx_r   <= vec_idx_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
        end
    end

    // Next-state logic: hold each vector, step through 00..11, then drain the pipeline
    always_comb begin
        state_nxt_s     = state_r;
        vec_idx_nxt_s   = vec_idx_r;
        hold_cnt_nxt_s  = hold_cnt_r;
        drain_cnt_nxt_s = drain_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s    = ST_DRIVE;
                    vec_idx_nxt_s  = 2'd0;
                    hold_cnt_nxt_s = HOLD_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    hold_cnt_nxt_s = HOLD_ZERO;
                    if (vec_idx_r == 2'd3) begin
                        state_nxt_s     = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
                        drain_cnt_nxt_s = DRAIN_ZERO;
                    end else begin
                        vec_idx_nxt_s = vec_idx_r + 2'd1;
                    end
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    drain_cnt_nxt_s = drain_cnt_r + DRAIN_ONE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign drive_nxt_s = (state_nxt_s == ST_DRIVE);

    // Registered stimulus and status, derived from the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= 1'b0;
            b_r    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            a_r    <= drive_nxt_s & vec_idx_nxt_s[1];
            b_r    <= drive_nxt_s & vec_idx_nxt_s[0];
            busy_r <= drive_nxt_s || (state_nxt_s == ST_DRAIN);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Entry format: {valid, expected, a, b} for the vector presented this cycle
    assign cur_s = {(state_r == ST_DRIVE), a_r & b_r, a_r, b_r};

    generate
        if (LATENCY > 0) begin : g_pipe
            logic [3:0] pipe_r [LATENCY];

            // Delay line matching the DUT latency
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        pipe_r[i] <= 4'b0000;
                    end
                end else begin
                    pipe_r[0] <= cur_s;
                    for (int i = 1; i < LATENCY; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end

            assign chk_s = pipe_r[LATENCY-1];
        end else begin : g_comb
            assign chk_s = cur_s;
        end
    endgenerate

    assign {chk_valid_s, chk_exp_s, chk_ab_s} = chk_s;

    // Result counters: cleared on accepted start, updated when a check entry emerges
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_r  <= CNT_ZERO;
            fail_cnt_r  <= CNT_ZERO;
            fail_flag_r <= 1'b0;
            err_vec_r   <= 2'b00;
        end else if (accept_s) begin
            pass_cnt_r  <= CNT_ZERO;
            fail_cnt_r  <= CNT_ZERO;
            fail_flag_r <= 1'b0;
            err_vec_r   <= 2'b00;
        end else if (chk_valid_s) begin
            if (y == chk_exp_s) begin
                pass_cnt_r <= sat_inc(pass_cnt_r);
            end else begin
                fail_cnt_r  <= sat_inc(fail_cnt_r);
                fail_flag_r <= 1'b1;
                err_vec_r   <= chk_ab_s;
            end
        end
    end

    assign a         = a_r;
    assign b         = b_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass_cnt  = pass_cnt_r;
    assign fail_cnt  = fail_cnt_r;
    assign fail_flag = fail_flag_r;
    assign err_vec   = err_vec_r;

endmodule

// File: tb/tb_and_stim_checker.sv
// Bench for and_stim_checker: several parameterisations, each driving a model
// cell (AND, OR, or AND with injected flips), checked cycle by cycle.
module tb_and_stim_checker;

    localparam int N = 6;
    localparam int HP [N] = '{1, 1, 3, 2, 2, 2};
    localparam int LP [N] = '{1, 1, 1, 1, 0, 2};
    localparam int CW [N] = '{8, 8, 8, 2, 8, 8};

    logic       clk;
    logic       start_s [N];
    logic       rst_s   [N];
    logic       y_w     [N];
    logic       a_w     [N];
    logic       b_w     [N];
    logic       busy_w  [N];
    logic       done_w  [N];
    logic       flag_w  [N];
    logic [7:0] pass_w  [N];
    logic [7:0] fail_w  [N];
    logic [1:0] err_w   [N];
    logic [1:0] pass3_w;
    logic [1:0] fail3_w;
    logic       inj_s;
    logic       y5_p1;

    int n_cmp;
    int n_mis;
    int last_p [N];
    int last_f [N];
    int last_e [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    and_stim_checker #(.HOLD_CYCLES(1), .LATENCY(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .y(y_w[0]), .a(a_w[0]), .b(b_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass_cnt(pass_w[0]), .fail_cnt(fail_w[0]),
        .fail_flag(flag_w[0]), .err_vec(err_w[0]));
    and_stim_checker #(.HOLD_CYCLES(1), .LATENCY(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .y(y_w[1]), .a(a_w[1]), .b(b_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass_cnt(pass_w[1]), .fail_cnt(fail_w[1]),
        .fail_flag(flag_w[1]), .err_vec(err_w[1]));
    and_stim_checker #(.HOLD_CYCLES(3), .LATENCY(1), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst_s[2]), .start(start_s[2]), .y(y_w[2]), .a(a_w[2]), .b(b_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass_cnt(pass_w[2]), .fail_cnt(fail_w[2]),
        .fail_flag(flag_w[2]), .err_vec(err_w[2]));
    and_stim_checker #(.HOLD_CYCLES(2), .LATENCY(1), .CNT_W(2)) u3 (
        .clk(clk), .rst(rst_s[3]), .start(start_s[3]), .y(y_w[3]), .a(a_w[3]), .b(b_w[3]),
        .busy(busy_w[3]), .done(done_w[3]), .pass_cnt(pass3_w), .fail_cnt(fail3_w),
        .fail_flag(flag_w[3]), .err_vec(err_w[3]));
    and_stim_checker #(.HOLD_CYCLES(2), .LATENCY(0), .CNT_W(8)) u4 (
        .clk(clk), .rst(rst_s[4]), .start(start_s[4]), .y(y_w[4]), .a(a_w[4]), .b(b_w[4]),
        .busy(busy_w[4]), .done(done_w[4]), .pass_cnt(pass_w[4]), .fail_cnt(fail_w[4]),
        .fail_flag(flag_w[4]), .err_vec(err_w[4]));
    and_stim_checker #(.HOLD_CYCLES(2), .LATENCY(2), .CNT_W(8)) u5 (
        .clk(clk), .rst(rst_s[5]), .start(start_s[5]), .y(y_w[5]), .a(a_w[5]), .b(b_w[5]),
        .busy(busy_w[5]), .done(done_w[5]), .pass_cnt(pass_w[5]), .fail_cnt(fail_w[5]),
        .fail_flag(flag_w[5]), .err_vec(err_w[5]));

    assign pass_w[3] = {6'b000000, pass3_w};
    assign fail_w[3] = {6'b000000, fail3_w};

    // Cells under test: registered AND, registered OR, comb AND, 2-deep AND with flips
    always_ff @(posedge clk) begin
        y_w[0] <= a_w[0] & b_w[0];
        y_w[1] <= a_w[1] | b_w[1];
        y_w[2] <= a_w[2] & b_w[2];
        y_w[3] <= a_w[3] & b_w[3];
        y5_p1  <= (a_w[5] & b_w[5]) ^ inj_s;
        y_w[5] <= y5_p1;
    end
    assign y_w[4] = a_w[4] & b_w[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s[u%0d]: observed %0h expected %0h", tag, id, obs, exp);
        end
    endtask

    task automatic check_outs(input int id, input int ea, input int eb, input int ebusy, input int edone,
                              input int ep, input int ef, input int eflag, input int eerr);
        check("a", id, 32'(a_w[id]), 32'(ea));
        check("b", id, 32'(b_w[id]), 32'(eb));
        check("busy", id, 32'(busy_w[id]), 32'(ebusy));
        check("done", id, 32'(done_w[id]), 32'(edone));
        check("pass_cnt", id, 32'(pass_w[id]), 32'(ep));
        check("fail_cnt", id, 32'(fail_w[id]), 32'(ef));
        check("fail_flag", id, 32'(flag_w[id]), 32'(eflag));
        check("err_vec", id, 32'(err_w[id]), 32'(eerr));
    endtask

    // One complete run on instance id; expectations come from the vector schedule
    // (vector k over cycles 1+kH..(k+1)H) and each check landing L+1 cycles later.
    task automatic run(input int id, input bit hold_start);
        int h, l, tot, vec, nchk, p, f, e, mx;
        bit match [64];
        bit flip  [64];
        bit ra, rb, resp;
        h   = HP[id];
        l   = LP[id];
        tot = 4 * h + l + 1;
        mx  = (1 << CW[id]) - 1;
        for (int t = 1; t <= 4 * h; t++) begin
            vec     = (t - 1) / h;
            ra      = vec[1];
            rb      = vec[0];
            flip[t] = (id == 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            resp    = ((id == 1) ? (ra | rb) : (ra & rb)) ^ flip[t];
            match[t] = (resp == (ra & rb));
        end
        tick();
        check("idle_busy", id, 32'(busy_w[id]), 32'd0);
        check("idle_pass", id, 32'(pass_w[id]), 32'(last_p[id]));
        start_s[id] = 1'b1;
        tick();
        for (int c = 1; c <= tot; c++) begin
            start_s[id] = hold_start ? 1'b1 : ((c < tot) ? 1'($urandom_range(0, 1)) : 1'b0);
            inj_s = (id == 5 && c <= 4 * h) ? flip[c] : 1'b0;
            vec  = (c <= 4 * h) ? (c - 1) / h : 0;
            nchk = c - l - 1;
            if (nchk < 0) nchk = 0;
            if (nchk > 4 * h) nchk = 4 * h;
            p = 0; f = 0; e = 0;
            for (int t = 1; t <= nchk; t++) begin
                if (match[t]) p++;
                else begin
                    f++;
                    e = (t - 1) / h;
                end
            end
            if (p > mx) p = mx;
            if (f > mx) f = mx;
            check_outs(id, vec / 2, vec % 2, (c <= 4 * h + l) ? 1 : 0, (c == tot) ? 1 : 0,
                       p, f, (f > 0) ? 1 : 0, e);
            last_p[id] = p;
            last_f[id] = f;
            last_e[id] = e;
            if (c < tot) tick();
        end
        inj_s = 1'b0;
    endtask

    task automatic idle_check(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_outs(id, 0, 0, 0, 0, last_p[id], last_f[id], (last_f[id] > 0) ? 1 : 0, last_e[id]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        inj_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            start_s[i] = 1'b0;
            rst_s[i]   = 1'b1;
            last_p[i]  = 0;
            last_f[i]  = 0;
            last_e[i]  = 0;
        end
        tick();
        tick();
        for (int i = 0; i < N; i++) begin
            check_outs(i, 0, 0, 0, 0, 0, 0, 0, 0);
            rst_s[i] = 1'b0;
        end

        run(0, 1'b0);
        idle_check(0, 2);
        run(1, 1'b0);
        check("or_err_vec", 1, 32'(err_w[1]), 32'd2);
        check("or_pass", 1, 32'(pass_w[1]), 32'd2);
        run(2, 1'b0);
        run(3, 1'b0);
        check("sat_pass", 3, 32'(pass_w[3]), 32'd3);
        run(4, 1'b0);
        idle_check(4, 2);
        for (int k = 0; k < 4; k++) begin
            run(5, 1'b0);
            idle_check(5, 1);
        end
        for (int k = 0; k < 8; k++) begin
            run($urandom_range(0, N - 1), 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end

        // start held high: back-to-back runs separated by one IDLE cycle
        run(0, 1'b1);
        run(0, 1'b1);
        start_s[0] = 1'b0;
        idle_check(0, 2);

        // mid-run reset: start in cycle 0, rst in cycle 3
        tick();
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", 0, 32'(busy_w[0]), 32'd1);
        rst_s[0] = 1'b1;
        tick();
        rst_s[0] = 1'b0;
        last_p[0] = 0;
        last_f[0] = 0;
        last_e[0] = 0;
        check_outs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_check(0, 8);
        run(0, 1'b0);
        check("post_rst_pass", 0, 32'(pass_w[0]), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/and_stim_checker.md
# and_stim_checker

Self-contained stimulus generator and response checker for the clocked two-input AND cell. On `start` it drives all four `{a,b}` input combinations into the cell under test, holding each for a fixed number of cycles. It compares the cell's registered output `y` against the expected `a & b` after a fixed DUT latency, and reports saturating pass/fail counts. It is the hardware counterpart of the concurrent `a==1 && b==1` check, and lets the cell be exercised on-chip or inside larger benches without a procedural testbench.

## Interface
Parameters:
- `HOLD_CYCLES`, default 1: cycles each vector is held; legal range ≥1.
- `LATENCY`, default 1: DUT clock latency from `a`/`b` to `y`; legal range ≥0, where 0 means combinational.
- `CNT_W`, default 8: width of the pass/fail counters.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a run; sampled only in IDLE.
- `y` input 1: response from the DUT.
- `a` output 1: registered stimulus bit to the DUT.
- `b` output 1: registered stimulus bit to the DUT.
- `busy` output 1: high in DRIVE and DRAIN.
- `done` output 1: one-cycle pulse at the end of a run.
- `pass_cnt` output CNT_W: number of matching samples.
- `fail_cnt` output CNT_W: number of mismatching samples.
- `fail_flag` output 1: sticky flag; set on the first mismatch of a run.
- `err_vec` output 2: `{a,b}` of the most recent mismatching sample.

## Operation
- FSM states: IDLE, DRIVE, DRAIN, DONE.
  - IDLE → DRIVE when `start` = 1.
  - DRIVE → DRAIN after 4·HOLD_CYCLES cycles.
  - DRAIN → DONE after LATENCY cycles. If LATENCY = 0, DRAIN is skipped: DRIVE → DONE.
  - DONE → IDLE unconditionally.
- Accepting `start` clears `pass_cnt`, `fail_cnt`, `fail_flag` and `err_vec` on the same edge.
- `start` is ignored in DRIVE, DRAIN and DONE. It has no queuing effect.
- Vector order: index 0..3 maps to `{a,b}` = 00, 01, 10, 11. A 2-bit vector index and a hold counter of width clog2(HOLD_CYCLES), minimum 1, advance the sequence.
- Outside DRIVE, `a` = `b` = 0.
- Every DRIVE cycle is checked, giving 4·HOLD_CYCLES checks per run.
- Check pipeline: a LATENCY-deep shift register carries {valid, expected = a&b, a, b}. A check fires when the pipeline output is valid.
  - Match → `pass_cnt` increments.
  - Mismatch → `fail_cnt` increments, `fail_flag` is set, and `err_vec` loads the pipelined `{a,b}`.
- Counters saturate at 2^CNT_W − 1. They never wrap.
- Results hold their values in IDLE until the next accepted `start`.

## Timing
- Reset values: `a` = `b` = 0, `busy` = 0, `done` = 0, `pass_cnt` = `fail_cnt` = 0, `fail_flag` = 0, `err_vec` = 00. State is IDLE and the pipeline valid bits are cleared.
- `rst` asserted mid-run aborts the run. No `done` pulse is generated. Next cycle is IDLE with reset values.
- `start` sampled high at the edge ending cycle T:
  - Vector k is driven in cycles T+1+k·H .. T+(k+1)·H, where H = HOLD_CYCLES.
  - `busy` = 1 in cycles T+1 .. T+4H+L, where L = LATENCY.
- A vector driven in cycle t:
  - `y` is sampled at the edge ending cycle t+L.
  - The counter update is visible in cycle t+L+1.
- `done` = 1 and `busy` = 0 in cycle T+4H+L+1. Final counts are valid in that cycle.
- Run length from start-accept to `done`: 4H+L+1 cycles.
- `start` asserted in the DONE cycle is ignored. `start` in the following IDLE cycle is accepted, giving back-to-back runs with a 1-cycle gap.

## Test plan
- Correct AND DUT, H=1, L=1, `start` in cycle 0:
  - `{a,b}` = 00, 01, 10, 11 in cycles 1–4.
  - `done` in cycle 6.
  - `pass_cnt` = 4, `fail_cnt` = 0, `fail_flag` = 0.
- OR gate substituted as DUT, H=1, L=1:
  - `pass_cnt` = 2, `fail_cnt` = 2.
  - `fail_flag` = 1, `err_vec` = 10.
- Correct DUT, H=3, L=1:
  - `{a,b}` = 01 held in cycles 4–6.
  - `done` in cycle 14.
  - `pass_cnt` = 12.
- CNT_W=2, H=2, L=1, correct DUT: `pass_cnt` saturates at 3; no wrap to 0.
- `rst` pulsed in cycle 3 of a run:
  - All outputs are at reset values from cycle 4.
  - No `done` pulse.
  - A new `start` afterwards completes normally with `pass_cnt` = 4.
- `start` held high continuously, H=1, L=1:
  - Runs start in cycles 0 and 7.
  - `done` in cycles 6 and 13.
  - Counters are cleared at each accepted `start`.
